// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern engine with step prescaler, four sequences and PWM brightness.
// One instance drives one LED bank; LED is the pattern gated by a free-running PWM compare.
module led_sequencer #(
   parameter int N_LEDS    = 4,
   parameter int DIV_WIDTH = 19,
   parameter int PWM_BITS  = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [1:0]           MODE,
   input  logic                 DIR,
   input  logic                 PAUSE,
   input  logic [DIV_WIDTH-1:0] STEP_DIV,
   input  logic [PWM_BITS-1:0]  BRIGHT,
   output logic [N_LEDS-1:0]    LED,
   output logic                 STEP_TICK
);

   localparam logic [N_LEDS-1:0] PAT_ONE = {{(N_LEDS-1){1'b0}}, 1'b1};

   logic [DIV_WIDTH-1:0] div_cnt;
   logic [N_LEDS-1:0]    pat;
   logic [N_LEDS-1:0]    pat_step;
   logic [N_LEDS-1:0]    seed;
   logic                 bdir;
   logic                 bdir_step;
   logic [1:0]           mode_q;
   logic [PWM_BITS-1:0]  pwm_cnt;
   logic                 pwm_on;
   logic                 mode_chg;
   logic                 tick;

   assign mode_chg = (MODE != mode_q);
   assign tick     = !mode_chg && !PAUSE && (div_cnt >= STEP_DIV);
   assign pwm_on   = (&BRIGHT) || (pwm_cnt < BRIGHT);
   assign seed     = (MODE == 2'd1 || MODE == 2'd2) ? PAT_ONE : '0;

   // Next pattern for a tick in the current (registered) mode.
   always_comb begin
      pat_step  = pat;
      bdir_step = bdir;
      case (mode_q)
         2'd0: pat_step = DIR ? {~pat[0], pat[N_LEDS-1:1]} : {pat[N_LEDS-2:0], ~pat[N_LEDS-1]};
         2'd1: pat_step = DIR ? {pat[0], pat[N_LEDS-1:1]} : {pat[N_LEDS-2:0], pat[N_LEDS-1]};
         2'd2: begin
            if (!bdir) begin
               pat_step = pat << 1;
               if (pat_step[N_LEDS-1]) bdir_step = 1'b1;
            end else begin
               pat_step = pat >> 1;
               if (pat_step[0]) bdir_step = 1'b0;
            end
         end
         default: pat_step = DIR ? (pat - PAT_ONE) : (pat + PAT_ONE);
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         div_cnt   <= '0;
         pat       <= '0;
         bdir      <= 1'b0;
         mode_q    <= 2'd0;
         pwm_cnt   <= '0;
         LED       <= '0;
         STEP_TICK <= 1'b0;
      end else begin
         mode_q    <= MODE;
         pwm_cnt   <= pwm_cnt + 1'b1;
         LED       <= pat & {N_LEDS{pwm_on}};
         STEP_TICK <= tick;
         // A mode change reseeds and restarts the step period, overriding pause and tick.
         if (mode_chg) begin
            pat     <= seed;
            bdir    <= 1'b0;
            div_cnt <= '0;
         end else if (!PAUSE) begin
            if (tick) begin
               div_cnt <= '0;
               pat     <= pat_step;
               bdir    <= bdir_step;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Parametrised LED pattern engine for the demo boards: an integrated step prescaler drives an N-wide pattern register through one of four selectable sequences.
- Adds direction control, pause, a runtime step period and PWM brightness.
- Sits between the board oscillator and the LED pins; one instance per LED bank.

Parameters:
N_LEDS, 4, number of LED outputs and pattern width; must be >= 2
DIV_WIDTH, 19, width of the step prescaler counter and of STEP_DIV
PWM_BITS, 4, brightness resolution; PWM period is 2^PWM_BITS clocks

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-high reset
MODE  input  2  pattern select: 0 Johnson, 1 one-hot rotate, 2 bounce, 3 binary count
DIR  input  1  0 = shift left / count up; 1 = shift right / count down; ignored in bounce mode
PAUSE  input  1  1 = freeze the prescaler and the pattern
STEP_DIV  input  DIV_WIDTH  step period minus one, in clocks
BRIGHT  input  PWM_BITS  LED duty control
LED  output  N_LEDS  registered, PWM-gated pattern
STEP_TICK  output  1  one-cycle pulse, high in the same cycle the pattern register updates

Behaviour:
- Reset, asynchronous, active-high. While RST is high, all state clears to zero: DIV_CNT, PAT, bounce direction BDIR (0 = up), MODE_Q, PWM_CNT, LED and STEP_TICK. Reset may be asserted at any time and takes effect immediately.
- Prescaler:
  - DIV_CNT increments each clock.
  - When DIV_CNT >= STEP_DIV, DIV_CNT returns to 0 and an internal tick fires.
  - STEP_DIV = 0 gives a tick every clock. Lowering STEP_DIV below the current DIV_CNT ticks on the next clock.
  - While PAUSE = 1, DIV_CNT, PAT and BDIR hold and no tick fires.
- Mode change:
  - MODE_Q registers MODE every clock.
  - In any cycle where MODE != MODE_Q, PAT loads the seed of the new MODE, BDIR goes to 0 and DIV_CNT goes to 0. No tick fires in that cycle and STEP_TICK stays 0.
  - Mode change takes priority over PAUSE and over tick.
  - Seeds: Johnson = all zero; one-hot = bit0 set; bounce = bit0 set with BDIR up; binary = zero.
  - MODE != 0 at reset release therefore loads its seed on the first clock.
- Tick actions (PAT updates and STEP_TICK = 1 on the same edge):
  - Johnson, DIR=0: PAT <= {PAT[N-2:0], ~PAT[N-1]}. DIR=1: PAT <= {~PAT[0], PAT[N-1:1]}. Period 2N steps.
  - One-hot: rotate left (DIR=0) or right (DIR=1). Period N steps.
  - Bounce: shift left while BDIR = 0, right while BDIR = 1. When the shift lands on bit N-1, BDIR sets; when it lands on bit 0, BDIR clears. Period 2N-2 steps; no end position repeats.
  - Binary: PAT + 1 (DIR=0) or PAT - 1 (DIR=1), modulo 2^N_LEDS.
  - A DIR change takes effect at the next tick with no reseed.
  - An illegal pattern (e.g. zero in one-hot or bounce after a direct state corruption) is not corrected except by a mode change or reset.
- PWM:
  - PWM_CNT is free-running modulo 2^PWM_BITS and is unaffected by PAUSE.
  - PWM_ON = (BRIGHT == all ones) or (PWM_CNT < BRIGHT).
  - BRIGHT = 0 keeps LEDs off; BRIGHT = max keeps them fully on; otherwise duty is BRIGHT / 2^PWM_BITS.
- Output: LED <= PAT & {N_LEDS{PWM_ON}}, registered. LED lags PAT by one clock.

Test Plan:
- N_LEDS=4, STEP_DIV=2, BRIGHT=15, MODE=0, DIR=0, release reset -> PAT runs 0000,0001,0011,0111,1111,1110,1100,1000,0000. STEP_TICK pulses every 3rd clock. LED matches PAT one clock later.
- Same setup with DIR=1 -> 0000,1000,1100,1110,1111,0111,0011,0001,0000. Set MODE=3, DIR=1 -> PAT seeds 0000, then 1111,1110,1101.
- MODE=2, STEP_DIV=0 -> PAT 0001,0010,0100,1000,0100,0010,0001,0010 on consecutive clocks; DIR toggling has no effect.
- Mid-run at DIV_CNT=1, switch MODE 0->1 with PAUSE=1 -> next clock PAT=0001, DIV_CNT=0, STEP_TICK=0. Pattern then holds while PAUSE=1. Release PAUSE -> ticks resume, 3 clocks later PAT=0010.
- PAT=1111, BRIGHT=4 -> LED=1111 for 4 of every 16 clocks. BRIGHT=0 -> LED=0000 always. BRIGHT=15 -> LED=1111 always.
- Assert RST asynchronously mid-step -> LED, STEP_TICK and PAT read 0 before the next clock edge. With MODE=1 held, first clock after release loads 0001.
